// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encodings, LED bank width
// and the scan one-hot helper.
package led_seq_pkg;

    localparam int LED_W = 10;
    localparam int POS_W = 4;
    localparam logic [POS_W-1:0] SCAN_LAST = 4'd9;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    function automatic logic [LED_W-1:0] pos_onehot(input logic [POS_W-1:0] pos);
        logic [LED_W-1:0] v;
        v = {{(LED_W-1){1'b0}}, 1'b1};
        return v << pos;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Pattern-step prescaler: one-cycle tick every TICK_DIV clocks, restartable
// from zero through clear (which takes priority over the wrap).
module tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick = (div_q == DIV_LAST);

    // Divider next value: clear, wrap on tick, else count up.
    always_comb begin
        div_d = div_q;
        if (clear) begin
            div_d = {DIV_W{1'b0}};
        end else if (tick) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            div_q <= {DIV_W{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED bank controller: synchronised switches and button drive a four-mode
// display (mirror, counter, bouncing scan, gated blink).
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [LED_W-1:0] SW,
    input  logic             mode_btn,
    output logic [LED_W-1:0] LEDR,
    output logic [1:0]       mode
);

    logic [LED_W-1:0] sw_m_q, sw_s_q;
    logic             btn_m_q, btn_s_q, btn_d_q;
    logic             rise;
    logic             tick;

    mode_e            mode_q, mode_d;
    logic [LED_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_up_q, dir_up_d;
    logic             phase_q, phase_d;
    logic [LED_W-1:0] led_q, led_d;

    assign rise = btn_s_q & ~btn_d_q;

    // Two-flop synchronisers plus the button edge-detect delay stage.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sw_m_q  <= {LED_W{1'b0}};
            sw_s_q  <= {LED_W{1'b0}};
            btn_m_q <= 1'b0;
            btn_s_q <= 1'b0;
            btn_d_q <= 1'b0;
        end else begin
            sw_m_q  <= SW;
            sw_s_q  <= sw_m_q;
            btn_m_q <= mode_btn;
            btn_s_q <= btn_m_q;
            btn_d_q <= btn_s_q;
        end
    end

    // A button edge restarts the prescaler so a new mode begins a full step.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clear    (rise),
        .tick     (tick)
    );

    // Mode, pattern state and LED output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_MIRROR;
            cnt_q    <= {LED_W{1'b0}};
            pos_q    <= {POS_W{1'b0}};
            dir_up_q <= 1'b1;
            phase_q  <= 1'b1;
            led_q    <= {LED_W{1'b0}};
        end else begin
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
        end
    end

    // Mode FSM next state: advance once per button edge.
    always_comb begin
        mode_d = mode_q;
        if (rise) begin
            case (mode_q)
                MODE_MIRROR: mode_d = MODE_COUNT;
                MODE_COUNT:  mode_d = MODE_SCAN;
                MODE_SCAN:   mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_MIRROR;
                default:     mode_d = MODE_MIRROR;
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    // Pattern state: a mode change reinitialises everything and swallows a coincident tick.
    always_comb begin
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        phase_d  = phase_q;
        if (rise) begin
            cnt_d    = {LED_W{1'b0}};
            pos_d    = {POS_W{1'b0}};
            dir_up_d = 1'b1;
            phase_d  = 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_COUNT: cnt_d = cnt_q + LED_W'(1);
                MODE_SCAN: begin
                    if (dir_up_q) begin
                        if (pos_q == SCAN_LAST) begin
                            dir_up_d = 1'b0;
                            pos_d    = SCAN_LAST - 4'd1;
                        end else begin
                            pos_d = pos_q + 4'd1;
                        end
                    end else begin
                        if (pos_q == 4'd0) begin
                            dir_up_d = 1'b1;
                            pos_d    = 4'd1;
                        end else begin
                            pos_d = pos_q - 4'd1;
                        end
                    end
                end
                MODE_BLINK: phase_d = ~phase_q;
                default:    cnt_d = cnt_q;
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // LED pattern for the current mode, registered one edge later.
    always_comb begin
        led_d = {LED_W{1'b0}};
        case (mode_q)
            MODE_MIRROR: led_d = sw_s_q;
            MODE_COUNT:  led_d = cnt_q;
            MODE_SCAN:   led_d = pos_onehot(pos_q);
            MODE_BLINK: begin
                if (phase_q) begin
                    led_d = sw_s_q;
                end else begin
                    led_d = {LED_W{1'b0}};
                end
            end
            default:     led_d = {LED_W{1'b0}};
        endcase
    end

    assign LEDR = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV = 4.
module tb_led_sequencer;

    logic       CLOCK_50;
    logic       reset;
    logic [9:0] SW;
    logic       mode_btn;
    logic [9:0] LEDR;
    logic [1:0] mode;

    int tests_run;
    int tests_failed;

    int exp_pos [19] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    led_sequencer #(.TICK_DIV(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .SW       (SW),
        .mode_btn (mode_btn),
        .LEDR     (LEDR),
        .mode     (mode)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Two-cycle press; returns just after the edge on which mode changes.
    task automatic press();
        mode_btn = 1'b1;
        step(2);
        mode_btn = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        tests_run++;
        if (LEDR !== 10'h000 || mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: LEDR=%h mode=%0d, want LEDR=000 mode=0", LEDR, mode);
        end
        reset = 1'b0;
        SW = 10'h3FF;
        step(3);
        tests_run++;
        if (LEDR !== 10'h3FF) begin
            tests_failed++;
            $display("FAIL mirror_first: LEDR=%h want 3ff", LEDR);
        end
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if (LEDR !== 10'h000 || mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_async: LEDR=%h mode=%0d, want 000/0", LEDR, mode);
        end
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        SW = 10'h155;
        step(2);
        tests_run++;
        if (LEDR !== 10'h000) begin
            tests_failed++;
            $display("FAIL mirror_latency_early: LEDR=%h want 000", LEDR);
        end
        step(1);
        tests_run++;
        if (LEDR !== 10'h155) begin
            tests_failed++;
            $display("FAIL mirror_latency: LEDR=%h want 155", LEDR);
        end
    endtask

    task automatic test_mode_advance();
        mode_btn = 1'b1;
        step(2);
        tests_run++;
        if (mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL btn_latency_early: mode=%0d want 0", mode);
        end
        step(1);
        tests_run++;
        if (mode !== 2'd1) begin
            tests_failed++;
            $display("FAIL btn_latency: mode=%0d want 1", mode);
        end
        step(17);
        mode_btn = 1'b0;
        step(5);
        tests_run++;
        if (mode !== 2'd1) begin
            tests_failed++;
            $display("FAIL btn_hold_once: mode=%0d want 1", mode);
        end
        for (int i = 2; i <= 4; i++) begin
            press();
            tests_run++;
            if (mode !== 2'(i % 4)) begin
                tests_failed++;
                $display("FAIL btn_press_%0d: mode=%0d want %0d", i, mode, i % 4);
            end
            step(3);
        end
    endtask

    task automatic test_count_wrap();
        press();
        tests_run++;
        if (mode !== 2'd1) begin
            tests_failed++;
            $display("FAIL count_enter: mode=%0d want 1", mode);
        end
        step(1);
        tests_run++;
        if (LEDR !== 10'd0) begin
            tests_failed++;
            $display("FAIL count_entry: LEDR=%0d want 0", LEDR);
        end
        for (int k = 1; k <= 1025; k++) begin
            step(4);
            tests_run++;
            if (LEDR !== 10'(k)) begin
                tests_failed++;
                $display("FAIL count_tick_%0d: LEDR=%0d want %0d", k, LEDR, k % 1024);
            end
        end
    endtask

    task automatic test_scan_bounce();
        logic [9:0] one;
        one = 10'd1;
        press();
        tests_run++;
        if (mode !== 2'd2) begin
            tests_failed++;
            $display("FAIL scan_enter: mode=%0d want 2", mode);
        end
        step(1);
        tests_run++;
        if (LEDR !== one) begin
            tests_failed++;
            $display("FAIL scan_entry: LEDR=%b want %b", LEDR, one);
        end
        for (int k = 0; k < 19; k++) begin
            step(4);
            tests_run++;
            if (LEDR !== (one << exp_pos[k])) begin
                tests_failed++;
                $display("FAIL scan_tick_%0d: LEDR=%b want %b", k + 1, LEDR, one << exp_pos[k]);
            end
        end
    endtask

    task automatic test_blink_collision();
        SW = 10'h3FF;
        press();
        tests_run++;
        if (mode !== 2'd3) begin
            tests_failed++;
            $display("FAIL blink_enter: mode=%0d want 3", mode);
        end
        step(1);
        tests_run++;
        if (LEDR !== 10'h3FF) begin
            tests_failed++;
            $display("FAIL blink_entry: LEDR=%h want 3ff", LEDR);
        end
        for (int k = 1; k <= 4; k++) begin
            step(4);
            tests_run++;
            if (LEDR !== ((k % 2 == 1) ? 10'h000 : 10'h3FF)) begin
                tests_failed++;
                $display("FAIL blink_tick_%0d: LEDR=%h want %h", k, LEDR,
                         (k % 2 == 1) ? 10'h000 : 10'h3FF);
            end
        end
        // Button edge registered on the same edge as the next tick.
        SW = 10'h2AA;
        mode_btn = 1'b1;
        step(2);
        mode_btn = 1'b0;
        tests_run++;
        if (mode !== 2'd3) begin
            tests_failed++;
            $display("FAIL collide_early: mode=%0d want 3", mode);
        end
        step(1);
        tests_run++;
        if (mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL collide_mode: mode=%0d want 0", mode);
        end
        step(1);
        tests_run++;
        if (LEDR !== 10'h2AA) begin
            tests_failed++;
            $display("FAIL collide_led: LEDR=%h want 2aa", LEDR);
        end
        step(3);
    endtask

    task automatic test_reset_midrun();
        press();
        step(6);
        tests_run++;
        if (LEDR !== 10'd1 || mode !== 2'd1) begin
            tests_failed++;
            $display("FAIL midrun_pre: LEDR=%0d mode=%0d want 1/1", LEDR, mode);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (LEDR !== 10'd0 || mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset: LEDR=%0d mode=%0d want 0/0", LEDR, mode);
        end
        step(1);
        reset = 1'b0;
        step(2);
        tests_run++;
        if (mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL midrun_after: mode=%0d want 0", mode);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset    = 1'b1;
        SW       = 10'h000;
        mode_btn = 1'b0;
        step(2);
        test_reset();
        test_mode_advance();
        test_count_wrap();
        test_scan_bounce();
        test_blink_collision();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
